// File: rtl/custom_types.sv
// Shared types for the 4-bit CPU program store: instruction word layout,
// store FSM states and memory depth.
package custom_types;

    localparam int IMEM_DEPTH = 16;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] operand;
    } instruction_t;

    typedef enum logic [2:0] {
        EMPTY,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } store_state_t;

endpackage

// File: rtl/imem_16x.sv
// 16-entry instruction register file: one synchronous write port, async read,
// async clear to zero, and a one-cycle clear of every entry at or above clear_from.
module imem_16x
    import custom_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  instruction_t wdata,
    input  logic         clear_en,
    input  logic [4:0]   clear_from,
    input  logic [3:0]   raddr,
    output instruction_t rdata
);

    instruction_t r_mem [IMEM_DEPTH];

    // clear_en wins over a write to the same entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                if (clear_en && (5'(i) >= clear_from)) begin
                    r_mem[i] <= '0;
                end else if (we && (waddr == 4'(i))) begin
                    r_mem[i] <= wdata;
                end
            end
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/instruction_store.sv
// Program store in front of the 4-bit CPU: loads LOAD_WORDS words plus an XOR
// checksum over a valid/ready stream and releases the CPU only after a good load.
module instruction_store
    import custom_types::*;
#(
    parameter int INSTR_W    = 8,
    parameter int LOAD_WORDS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    output logic               load_ready,
    input  logic [3:0]         fetch_addr,
    output instruction_t       instruction,
    output logic               cpu_reset,
    output logic               running,
    output logic               load_error,
    output store_state_t       dbg_state
);

    // Handshake: a word transfers on a rising edge where load_valid && load_ready.
    // load_ready is a registered function of state only; load_start overrides it.

    store_state_t       r_state;
    logic [3:0]         r_wptr;
    logic [INSTR_W-1:0] r_csum;
    logic               r_load_ready;
    logic               r_cpu_reset;
    logic               r_running;
    logic               r_load_error;

    store_state_t       w_next_state;
    logic [3:0]         w_next_wptr;
    logic [INSTR_W-1:0] w_next_csum;
    logic               w_accept;
    logic               w_we;
    logic               w_clear;

    assign w_accept = load_valid && r_load_ready;

    always_comb begin
        w_next_state = r_state;
        w_next_wptr  = r_wptr;
        w_next_csum  = r_csum;
        w_we         = 1'b0;
        w_clear      = 1'b0;
        if (load_start) begin
            w_next_state = LOAD;
            w_next_wptr  = '0;
            w_next_csum  = '0;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        w_we        = 1'b1;
                        w_next_csum = r_csum ^ load_data;
                        w_next_wptr = r_wptr + 4'd1;
                        if (r_wptr == 4'(LOAD_WORDS - 1)) begin
                            w_next_state = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_accept) begin
                        w_next_state = (load_data == r_csum) ? RUN : ERROR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= EMPTY;
            r_wptr       <= '0;
            r_csum       <= '0;
            r_load_ready <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_running    <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_wptr       <= w_next_wptr;
            r_csum       <= w_next_csum;
            r_load_ready <= (w_next_state == LOAD) || (w_next_state == CHECK);
            r_cpu_reset  <= (w_next_state != RUN);
            r_running    <= (w_next_state == RUN);
            r_load_error <= (w_next_state == ERROR);
        end
    end

    imem_16x u_imem (
        .clk        (clk),
        .rst        (reset),
        .we         (w_we),
        .waddr      (r_wptr),
        .wdata      (instruction_t'(load_data)),
        .clear_en   (w_clear),
        .clear_from (5'(LOAD_WORDS)),
        .raddr      (fetch_addr),
        .rdata      (instruction)
    );

    assign load_ready = r_load_ready;
    assign cpu_reset  = r_cpu_reset;
    assign running    = r_running;
    assign load_error = r_load_error;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_instruction_store.sv
// Bench for instruction_store: a 16-word and a 4-word instance share the load
// stream; expected memory and status come from a simple array model of a load.
module tb_instruction_store;
    import custom_types::*;

    logic clk = 1'b0;
    logic reset;
    logic load_start;
    logic load_valid;
    logic [7:0] load_data;
    logic [3:0] fetch_addr;

    logic rdy16, cpur16, run16, err16;
    instruction_t ins16;
    store_state_t st16;
    logic rdy4, cpur4, run4, err4;
    instruction_t ins4;
    store_state_t st4;

    int n_checks = 0;
    int n_fail = 0;
    logic use4 = 1'b0;
    logic [7:0] wbuf [16];
    logic [7:0] ref_mem [16];
    logic [7:0] act_mem [16];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    instruction_store #(.INSTR_W(8), .LOAD_WORDS(16)) u16 (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(rdy16), .fetch_addr(fetch_addr),
        .instruction(ins16), .cpu_reset(cpur16), .running(run16),
        .load_error(err16), .dbg_state(st16)
    );

    instruction_store #(.INSTR_W(8), .LOAD_WORDS(4)) u4 (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(rdy4), .fetch_addr(fetch_addr),
        .instruction(ins4), .cpu_reset(cpur4), .running(run4),
        .load_error(err4), .dbg_state(st4)
    );

    // ---------------- clock / reset ----------------
    task automatic do_reset();
        reset = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        fetch_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d);
        logic rdy_now;
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data = d;
        do begin
            rdy_now = use4 ? rdy4 : rdy16;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy_now && n < 50);
        load_valid = 1'b0;
        if (!rdy_now) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: no load_ready within %0d cycles for word %h", n, d);
        end
    endtask

    // gap_mode 0: back-to-back, 1: toggle valid + 7-cycle gap after 8th word, 2: random gaps
    task automatic send_load(input int n, input int gap_mode);
        pulse_start();
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1) idle(1);
            if (gap_mode == 2) idle($urandom_range(0, 3));
            send_word(wbuf[i]);
            if (gap_mode == 1 && i == 7) idle(7);
        end
    endtask

    task automatic read_all(input logic sel4);
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a);
            #1;
            act_mem[a] = sel4 ? ins4 : ins16;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xor_of(input int n);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < n; i++) x ^= wbuf[i];
        return x;
    endfunction

    // After a load of lw words: entries below lw hold the words, the rest read 0.
    task automatic model_load(input int lw);
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = (i < lw) ? wbuf[i] : 8'h00;
            exp_q.push_back(ref_mem[i]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        idle(10);
        n_checks++;
        if (cpur16 !== 1'b1 || run16 !== 1'b0 || rdy16 !== 1'b0 || err16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs16: cpu_reset=%b running=%b ready=%b err=%b, want 1 0 0 0",
                     cpur16, run16, rdy16, err16);
        end
        n_checks++;
        if (cpur4 !== 1'b1 || run4 !== 1'b0 || rdy4 !== 1'b0 || err4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs4: cpu_reset=%b running=%b ready=%b err=%b, want 1 0 0 0",
                     cpur4, run4, rdy4, err4);
        end
        n_checks++;
        if (st16 !== EMPTY) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", st16, EMPTY);
        end
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a);
            #1;
            n_checks++;
            if (ins16 !== 8'h00 || ins4 !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_mem[%0d]: got %h/%h want 00", a, ins16, ins4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        use4 = 1'b0;
        for (int i = 0; i < 16; i++) wbuf[i] = 8'h10 + 8'(i);
        send_load(16, 0);
        n_checks++;
        if (st16 !== CHECK || run16 !== 1'b0 || rdy16 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_before_csum: state=%0d running=%b ready=%b want CHECK 0 1", st16, run16, rdy16);
        end
        send_word(8'h00);
        n_checks++;
        if (run16 !== 1'b1 || cpur16 !== 1'b0 || err16 !== 1'b0 || rdy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_run: running=%b cpu_reset=%b err=%b ready=%b want 1 0 0 0",
                     run16, cpur16, err16, rdy16);
        end
        fetch_addr = 4'd5;
        #1;
        n_checks++;
        if (ins16 !== 8'h15) begin
            n_fail++;
            $display("FAIL b2b_fetch5: got %h want 15", ins16);
        end
        read_all(1'b0);
        model_load(16);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (act_mem[a] !== e) begin
                n_fail++;
                $display("FAIL b2b_mem[%0d]: got %h want %h", a, act_mem[a], e);
            end
        end
    endtask

    task automatic test_gaps();
        use4 = 1'b0;
        for (int i = 0; i < 16; i++) wbuf[i] = 8'h10 + 8'(i);
        send_load(16, 1);
        idle(3);
        n_checks++;
        if (run16 !== 1'b0 || cpur16 !== 1'b1 || st16 !== CHECK) begin
            n_fail++;
            $display("FAIL gaps_wait_csum: running=%b cpu_reset=%b state=%0d want 0 1 CHECK", run16, cpur16, st16);
        end
        send_word(xor_of(16));
        n_checks++;
        if (run16 !== 1'b1 || cpur16 !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_run: running=%b cpu_reset=%b want 1 0", run16, cpur16);
        end
        read_all(1'b0);
        model_load(16);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (act_mem[a] !== e) begin
                n_fail++;
                $display("FAIL gaps_mem[%0d]: got %h want %h", a, act_mem[a], e);
            end
        end
    endtask

    task automatic test_bad_checksum();
        use4 = 1'b0;
        for (int i = 0; i < 16; i++) wbuf[i] = 8'h10 + 8'(i);
        send_load(16, 0);
        send_word(8'hFF);
        idle(3);
        n_checks++;
        if (err16 !== 1'b1 || cpur16 !== 1'b1 || run16 !== 1'b0 || st16 !== ERROR || rdy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_csum: err=%b cpu_reset=%b running=%b state=%0d ready=%b want 1 1 0 ERROR 0",
                     err16, cpur16, run16, st16, rdy16);
        end
        read_all(1'b0);
        model_load(16);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (act_mem[a] !== e) begin
                n_fail++;
                $display("FAIL bad_csum_mem[%0d]: got %h want %h", a, act_mem[a], e);
            end
        end
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        if (wbuf[0] == 8'hAA || wbuf[0] == 8'h55) wbuf[0] = 8'h01;
        send_load(16, 2);
        send_word(xor_of(16));
        n_checks++;
        if (err16 !== 1'b0 || run16 !== 1'b1 || cpur16 !== 1'b0) begin
            n_fail++;
            $display("FAIL recover_run: err=%b running=%b cpu_reset=%b want 0 1 0", err16, run16, cpur16);
        end
        read_all(1'b0);
        model_load(16);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (act_mem[a] !== e) begin
                n_fail++;
                $display("FAIL recover_mem[%0d]: got %h want %h", a, act_mem[a], e);
            end
        end
    endtask

    task automatic test_start_in_run();
        use4 = 1'b0;
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data = 8'hAA;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        load_valid = 1'b0;
        n_checks++;
        if (cpur16 !== 1'b1 || run16 !== 1'b0 || rdy16 !== 1'b1 || st16 !== LOAD) begin
            n_fail++;
            $display("FAIL restart_outputs: cpu_reset=%b running=%b ready=%b state=%0d want 1 0 1 LOAD",
                     cpur16, run16, rdy16, st16);
        end
        fetch_addr = 4'd0;
        #1;
        n_checks++;
        if (ins16 !== ref_mem[0]) begin
            n_fail++;
            $display("FAIL restart_no_write: mem[0]=%h want %h", ins16, ref_mem[0]);
        end
        @(posedge clk);
        #1;
        send_word(8'h55);
        fetch_addr = 4'd0;
        #1;
        n_checks++;
        if (ins16 !== 8'h55) begin
            n_fail++;
            $display("FAIL restart_wptr0: mem[0]=%h want 55", ins16);
        end
        fetch_addr = 4'd1;
        #1;
        n_checks++;
        if (ins16 !== ref_mem[1]) begin
            n_fail++;
            $display("FAIL restart_mem1: mem[1]=%h want %h", ins16, ref_mem[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        use4 = 1'b0;
        for (int it = 0; it < 6; it++) begin
            logic bad;
            logic [7:0] cs;
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            bad = ($urandom_range(0, 2) == 0);
            cs = xor_of(16) ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
            send_load(16, 2);
            send_word(cs);
            n_checks++;
            if (run16 !== !bad || err16 !== bad || cpur16 !== bad) begin
                n_fail++;
                $display("FAIL rand%0d_status: running=%b err=%b cpu_reset=%b bad=%b", it, run16, err16, cpur16, bad);
            end
            read_all(1'b0);
            model_load(16);
            for (int a = 0; a < 16; a++) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (act_mem[a] !== e) begin
                    n_fail++;
                    $display("FAIL rand%0d_mem[%0d]: got %h want %h", it, a, act_mem[a], e);
                end
            end
        end
    endtask

    task automatic test_load4();
        use4 = 1'b1;
        wbuf[0] = 8'h31;
        wbuf[1] = 8'h32;
        wbuf[2] = 8'h33;
        wbuf[3] = 8'h34;
        send_load(4, 0);
        n_checks++;
        if (st4 !== CHECK || run4 !== 1'b0) begin
            n_fail++;
            $display("FAIL lw4_check: state=%0d running=%b want CHECK 0", st4, run4);
        end
        send_word(8'h04);
        n_checks++;
        if (run4 !== 1'b1 || cpur4 !== 1'b0 || err4 !== 1'b0) begin
            n_fail++;
            $display("FAIL lw4_run: running=%b cpu_reset=%b err=%b want 1 0 0", run4, cpur4, err4);
        end
        read_all(1'b1);
        model_load(4);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (act_mem[a] !== e) begin
                n_fail++;
                $display("FAIL lw4_mem[%0d]: got %h want %h", a, act_mem[a], e);
            end
        end
        // mid-load async reset after the second word
        wbuf[0] = 8'($urandom_range(1, 255));
        wbuf[1] = 8'($urandom_range(1, 255));
        pulse_start();
        send_word(wbuf[0]);
        send_word(wbuf[1]);
        fetch_addr = 4'd1;
        #1;
        n_checks++;
        if (ins4 !== wbuf[1] || st4 !== LOAD) begin
            n_fail++;
            $display("FAIL lw4_midload: mem[1]=%h state=%0d want %h LOAD", ins4, st4, wbuf[1]);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (cpur4 !== 1'b1 || run4 !== 1'b0 || rdy4 !== 1'b0 || err4 !== 1'b0 || st4 !== EMPTY) begin
            n_fail++;
            $display("FAIL async_reset: cpu_reset=%b running=%b ready=%b err=%b state=%0d want 1 0 0 0 EMPTY",
                     cpur4, run4, rdy4, err4, st4);
        end
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a);
            #1;
            n_checks++;
            if (ins4 !== 8'h00) begin
                n_fail++;
                $display("FAIL async_reset_mem[%0d]: got %h want 00", a, ins4);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        use4 = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_bad_checksum();
        test_start_in_run();
        test_random();
        test_load4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
